// File: rtl/gray_bcd_scan_display.sv
// gray_bcd_scan_display
//   Takes a WIDTH-bit Gray code from the board switches and synchronises it.
//   Decodes it to binary and converts it to BCD with a sequential
//   double-dabble engine, one iteration per clock. The BCD result drives a
//   DIGITS-wide multiplexed 7-segment display with leading-zero blanking.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   gray_code  Gray-coded switch value, asynchronous to clk
//   seg        segment drive, active-high, seg[0]=a .. seg[6]=g (registered)
//   an         digit enables, active-low one-hot, an[0] = units (registered)
//   bcd        last converted value, nibble i = decimal digit i (registered)
//   busy       high while a conversion is running (registered)
//   valid      one-cycle pulse in the cycle bcd takes a new value (registered)

module gray_bcd_scan_display #(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 27000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      gray_code,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  valid
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(WIDTH);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Refuse to build a display that cannot show the full input range.
    generate
        if (WIDTH < 2 || WIDTH > 12) begin : g_bad_width
            $error("gray_bcd_scan_display: WIDTH must be 2..12");
        end
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("gray_bcd_scan_display: SCAN_DIV must be at least 2");
        end
        if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_too_few_digits
            $error("gray_bcd_scan_display: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // One double-dabble iteration: correct every nibble >= 5, then shift.
    function automatic logic [BCD_W+WIDTH-1:0] dd_step(input logic [BCD_W-1:0] acc,
                                                        input logic [WIDTH-1:0] sh);
        logic [BCD_W-1:0] adj;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? (acc[4*i +: 4] + 4'd3) : acc[4*i +: 4];
        end
        return {adj, sh} << 1'b1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [WIDTH-1:0]       r_sync1;
    logic [WIDTH-1:0]       r_sync2;
    logic [WIDTH-1:0]       r_last_bin;
    logic [WIDTH-1:0]       r_shift;
    logic [BCD_W-1:0]       r_acc;
    logic [ITER_W-1:0]      r_iter;
    logic [BCD_W-1:0]       r_bcd;
    logic                   r_busy;
    logic                   r_valid;
    logic [SCAN_W-1:0]      r_scan_cnt;
    logic [IDX_W-1:0]       r_digit_idx;
    logic [6:0]             r_seg;
    logic [DIGITS-1:0]      r_an;
    state_t                 r_state;
    state_t                 w_state_next;

    logic [WIDTH-1:0]       w_decode;
    logic                   w_start;
    logic                   w_last_iter;
    logic [BCD_W+WIDTH-1:0] w_step;
    logic [3:0]             w_cur_nib;
    logic                   w_cur_blank;
    logic                   w_higher_zero;

    assign w_decode    = gray2bin(r_sync2);
    assign w_start     = (r_state == ST_IDLE) && (w_decode != r_last_bin);
    assign w_last_iter = (r_iter == ITER_W'(WIDTH - 1));
    assign w_step      = dd_step(r_acc, r_shift);

    assign seg   = r_seg;
    assign an    = r_an;
    assign bcd   = r_bcd;
    assign busy  = r_busy;
    assign valid = r_valid;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gray_code;
            r_sync2 <= r_sync1;
        end
    end

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Conversion FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last_iter) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Double-dabble datapath, result register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_bin <= '0;
            r_shift    <= '0;
            r_acc      <= '0;
            r_iter     <= '0;
            r_bcd      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_start) begin
                        r_shift    <= w_decode;
                        r_acc      <= '0;
                        r_last_bin <= w_decode;
                        r_iter     <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_acc, r_shift} <= w_step;
                    r_iter           <= r_iter + ITER_W'(1);
                    if (w_last_iter) begin
                        r_bcd   <= w_step[BCD_W+WIDTH-1 -: BCD_W];
                        r_valid <= 1'b1;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
            r_busy <= (w_state_next == ST_SHIFT);
        end
    end

    // Select the lit digit's nibble; a digit is blank when it and every
    // more-significant nibble are zero, except the units digit.
    always_comb begin
        w_cur_nib     = 4'd0;
        w_cur_blank   = 1'b0;
        w_higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_higher_zero = w_higher_zero && (r_bcd[4*i +: 4] == 4'd0);
            w_cur_nib     = (r_digit_idx == IDX_W'(i)) ? r_bcd[4*i +: 4] : w_cur_nib;
            w_cur_blank   = (r_digit_idx == IDX_W'(i)) ? (w_higher_zero && (i != 0)) : w_cur_blank;
        end
    end

    // Scan timer, digit pointer and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_an        <= {DIGITS{1'b1}};
            r_seg       <= 7'h00;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : (r_digit_idx + IDX_W'(1));
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            r_an  <= ~(DIGITS'(1) << r_digit_idx);
            r_seg <= w_cur_blank ? 7'h00 : seg7(w_cur_nib);
        end
    end

endmodule

// File: tb/tb_gray_bcd_scan_display.sv
// Self-checking bench for gray_bcd_scan_display: a narrow instance
// (WIDTH=4, DIGITS=2, SCAN_DIV=4) and a wide one (WIDTH=8, DIGITS=3,
// SCAN_DIV=4) run side by side against a cycle model built from decimal
// arithmetic, plus literal expectations for the named scenarios.

module tb_gray_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_a = 4'd0;
    logic [7:0] gray_b = 8'd0;
    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a;
    logic [2:0] an_b;
    logic [7:0] bcd_a;
    logic [11:0] bcd_b;
    logic busy_a, busy_b, valid_a, valid_b;

    int n_checks = 0;
    int n_errors = 0;

    gray_bcd_scan_display #(.WIDTH(4), .DIGITS(2), .SCAN_DIV(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .gray_code(gray_a), .seg(seg_a), .an(an_a),
        .bcd(bcd_a), .busy(busy_a), .valid(valid_a)
    );

    gray_bcd_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .gray_code(gray_b), .seg(seg_b), .an(an_b),
        .bcd(bcd_b), .busy(busy_b), .valid(valid_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int s1; int s2;       // gray value seen one / two edges ago
        int last;             // binary value of last started conversion
        int left;             // busy cycles still to run
        int pending;          // value being converted
        int val;              // value currently shown on bcd (integer)
        int valid;
        int seg; int an;
        int edges;            // edges since reset release
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset(input int dg);
        model_t m;
        m.s1 = 0; m.s2 = 0; m.last = 0; m.left = 0; m.pending = 0;
        m.val = 0; m.valid = 0; m.seg = 0; m.an = (1 << dg) - 1; m.edges = 0;
        return m;
    endfunction

    function automatic int to_bcd(input int val, input int dg);
        int r = 0;
        int v = val;
        for (int i = 0; i < dg; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int seg_of(input int val, input int d);
        int p = 1;
        int dig;
        for (int k = 0; k < d; k++) p = p * 10;
        dig = (val / p) % 10;
        if (d > 0 && val < p) return 0;
        case (dig)
            0: return 32'h3F; 1: return 32'h06; 2: return 32'h5B; 3: return 32'h4F;
            4: return 32'h66; 5: return 32'h6D; 6: return 32'h7D; 7: return 32'h07;
            8: return 32'h7F; 9: return 32'h6F;
            default: return 0;
        endcase
    endfunction

    function automatic model_t model_step(input model_t m, input int g, input int w,
                                          input int dg, input int sd);
        model_t n;
        int dec;
        int d;
        n = m;
        dec = m.s2;
        for (int k = 1; k < w; k++) dec = dec ^ (m.s2 >> k);
        n.valid = 0;
        if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.val = m.pending;
                n.valid = 1;
            end
        end else if (dec != m.last) begin
            n.last = dec;
            n.pending = dec;
            n.left = w;
        end
        n.s2 = m.s1;
        n.s1 = g;
        d = (m.edges / sd) % dg;
        n.an = (~(1 << d)) & ((1 << dg) - 1);
        n.seg = seg_of(m.val, d);
        n.edges = m.edges + 1;
        return n;
    endfunction

    initial begin
        ma = model_reset(2);
        mb = model_reset(3);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ma = model_reset(2);
                mb = model_reset(3);
            end else begin
                ma = model_step(ma, 32'(gray_a), 4, 2, 4);
                mb = model_step(mb, 32'(gray_b), 8, 3, 4);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_an(input int which);
        return (which == 0) ? 32'(an_a) : 32'(an_b);
    endfunction
    function automatic logic [31:0] get_seg(input int which);
        return (which == 0) ? 32'(seg_a) : 32'(seg_b);
    endfunction
    function automatic logic [31:0] get_bcd(input int which);
        return (which == 0) ? 32'(bcd_a) : 32'(bcd_b);
    endfunction
    function automatic logic get_valid(input int which);
        return (which == 0) ? valid_a : valid_b;
    endfunction
    function automatic logic get_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    task automatic wait_valid(input int which, input int budget, input string name, output int lat);
        lat = -1;
        for (int i = 1; i <= budget && lat < 0; i++) begin
            @(negedge clk);
            if (get_valid(which)) lat = i;
        end
        if (lat < 0) check({name, "_valid_seen"}, 32'(get_valid(which)), 32'd1);
    endtask

    task automatic wait_busy(input int which, input int budget, input string name);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (get_busy(which)) seen = 1;
        end
        if (seen == 0) check({name, "_busy_seen"}, 32'(get_busy(which)), 32'd1);
    endtask

    task automatic find_digit(input int which, input logic [31:0] an_want,
                              input logic [31:0] seg_want, input string name);
        int found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            @(negedge clk);
            if (get_an(which) == an_want) begin
                found = 1;
                check(name, get_seg(which), seg_want);
            end
        end
        if (found == 0) check({name, "_an_seen"}, get_an(which), an_want);
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("a_seg",   32'(seg_a),   ma.seg);
            check("a_an",    32'(an_a),    ma.an);
            check("a_bcd",   32'(bcd_a),   to_bcd(ma.val, 2));
            check("a_busy",  32'(busy_a),  32'(ma.left > 0));
            check("a_valid", 32'(valid_a), ma.valid);
            check("b_seg",   32'(seg_b),   mb.seg);
            check("b_an",    32'(an_b),    mb.an);
            check("b_bcd",   32'(bcd_b),   to_bcd(mb.val, 3));
            check("b_busy",  32'(busy_b),  32'(mb.left > 0));
            check("b_valid", 32'(valid_b), mb.valid);
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [1:0] an_seq [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        int lat;
        int npulse;
        logic [7:0] pulse_bcd [2];

        rst_n  = 1'b0;
        gray_a = 4'($urandom_range(0, 7));
        gray_b = 8'($urandom_range(1, 127));
        repeat (3) @(negedge clk);
        check("rst_seg",   32'(seg_a),   32'h00);
        check("rst_an",    32'(an_a),    32'h3);
        check("rst_bcd",   32'(bcd_a),   32'h00);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_an_b",  32'(an_b),    32'h7);

        // Release and watch the scan order from the very first edge.
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("scan_order", 32'(an_a), 32'(an_seq[i]));
            if (i == 0) check("first_seg", 32'(seg_a), 32'h3F);
        end

        // Full-scale value.
        gray_a = 4'b1000;
        wait_valid(0, 20, "full", lat);
        check("full_latency", 32'(lat), 32'd7);
        check("full_bcd", 32'(bcd_a), 32'h15);
        find_digit(0, 32'b10, 32'h6D, "full_d0");
        find_digit(0, 32'b01, 32'h06, "full_d1");

        // Leading-zero blanking.
        gray_a = 4'b0111;
        wait_valid(0, 20, "blank", lat);
        check("blank_bcd", 32'(bcd_a), 32'h05);
        find_digit(0, 32'b01, 32'h00, "blank_d1");
        find_digit(0, 32'b10, 32'h6D, "blank_d0");

        // Input change while converting.
        gray_a = 4'b1000;
        wait_busy(0, 20, "chg");
        @(negedge clk);
        gray_a = 4'b1101;
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid_a) begin
                if (npulse < 2) pulse_bcd[npulse] = bcd_a;
                npulse++;
            end
        end
        check("chg_pulses", 32'(npulse), 32'd2);
        if (npulse >= 2) begin
            check("chg_bcd0", 32'(pulse_bcd[0]), 32'h15);
            check("chg_bcd1", 32'(pulse_bcd[1]), 32'h09);
        end

        // Reset in the middle of a conversion.
        gray_a = 4'b0111;
        wait_busy(0, 20, "mid");
        #2 rst_n = 1'b0;
        #1;
        check("mid_seg",   32'(seg_a),   32'h00);
        check("mid_an",    32'(an_a),    32'h3);
        check("mid_bcd",   32'(bcd_a),   32'h00);
        check("mid_busy",  32'(busy_a),  32'd0);
        check("mid_valid", 32'(valid_a), 32'd0);
        check("mid_bcd_b", 32'(bcd_b),   32'h000);
        gray_a = 4'b1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(0, 20, "mid_re", lat);
        check("mid_re_latency", 32'(lat), 32'd7);
        check("mid_re_bcd", 32'(bcd_a), 32'h15);
        repeat (12) @(negedge clk);

        // Wide configuration.
        gray_b = 8'b1000_0000;
        wait_valid(1, 30, "wide", lat);
        check("wide_latency", 32'(lat), 32'd11);
        check("wide_bcd", 32'(bcd_b), 32'h255);
        gray_b = 8'd0;
        wait_valid(1, 30, "wide0", lat);
        check("wide0_bcd", 32'(bcd_b), 32'h000);
        find_digit(1, 32'b101, 32'h00, "wide0_d1");
        find_digit(1, 32'b011, 32'h00, "wide0_d2");
        find_digit(1, 32'b110, 32'h3F, "wide0_d0");

        // Random traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 60; i++) begin
            gray_a = 4'($urandom_range(0, 15));
            gray_b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
